wb_dma_wb_mst_ctrl: RTL and testbench

//  WISHBONE initiator port of the DMA core; the counterpart of the register-file/pass-through slave port.

---
 rtl/wb_dma_wb_mst_ctrl_pkg.sv | 31 +++
 rtl/wb_dma_wb_mst_ctrl_if.sv | 23 ++
 rtl/wb_dma_wb_mst_ctrl_tmr.sv | 44 ++++
 rtl/wb_dma_wb_mst_ctrl.sv | 154 +++++++++++++++
 tb/tb_wb_dma_wb_mst_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dma_wb_mst_ctrl_pkg.sv
// Shared definitions for the DMA WISHBONE initiator: FSM encoding,
// pass-through bundle field offsets and counter widths.
package wb_dma_wb_mst_ctrl_pkg;

  // One-hot FSM encoding
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_REQ   = 4'b0010,
    ST_RETRY = 4'b0100,
    ST_PT    = 4'b1000
  } state_t;

  // Field offsets inside mast_pt_in
  localparam int PT_DATA = 39;
  localparam int PT_ADR  = 7;
  localparam int PT_SEL  = 3;
  localparam int PT_WE   = 2;
  localparam int PT_CYC  = 1;
  localparam int PT_STB  = 0;

  // Counter widths
  localparam int RTY_W = 3;
  localparam int TO_W  = 8;

  // Packs a slave response into the mast_pt_out layout
  function automatic logic [34:0] pt_resp(input logic [31:0] data, input logic ack,
                                          input logic err, input logic rty);
    return {data, ack, err, rty};
  endfunction

endpackage

// File: rtl/wb_dma_wb_mst_ctrl_if.sv
// WISHBONE bus bundle between the DMA initiator and the external slave.
interface wb_dma_wb_mst_ctrl_if;
  logic [31:0] wb_data_o;
  logic [31:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    output wb_data_o, wb_addr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_data_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_data_o, wb_addr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_data_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_dma_wb_mst_ctrl_tmr.sv
// Retry and timeout counters for one engine transfer. Both clear when a
// transfer starts; the timeout counter also clears for every retry.
module wb_dma_wb_mst_ctrl_tmr
  import wb_dma_wb_mst_ctrl_pkg::*;
#(
  parameter int RTY_MAX = 7,
  parameter int TO_CYC  = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_all,
  input  logic clr_to,
  input  logic inc_rty,
  input  logic inc_to,
  output logic rty_exp,
  output logic to_exp
);

  logic [RTY_W-1:0] rty_cnt;
  logic [TO_W-1:0]  to_cnt;

  // Counter updates; increments are only requested below the limits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rty_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (clr_all)
        rty_cnt <= '0;
      else if (inc_rty)
        rty_cnt <= rty_cnt + 1'b1;

      if (clr_all || clr_to)
        to_cnt <= '0;
      else if (inc_to)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // The current REQ cycle is the TO_CYC-th one once to_cnt reaches TO_CYC-1
  assign rty_exp = (rty_cnt == RTY_W'(RTY_MAX));
  assign to_exp  = (to_cnt == TO_W'(TO_CYC - 1));

endmodule

// File: rtl/wb_dma_wb_mst_ctrl.sv
// WISHBONE initiator of the DMA core. Turns engine single-word requests into
// classic cycles with bounded retry/timeout, and lends the bus to the host
// pass-through path. Each engine transfer ends in exactly one drdy or err.
module wb_dma_wb_mst_ctrl
  import wb_dma_wb_mst_ctrl_pkg::*;
#(
  parameter int RTY_MAX = 7,
  parameter int TO_CYC  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mast_go,
  input  logic        mast_we,
  input  logic [31:0] mast_adr,
  input  logic [3:0]  mast_sel,
  input  logic [31:0] mast_din,
  output logic [31:0] mast_dout,
  output logic        mast_drdy,
  output logic        mast_err,
  output logic        mast_busy,
  input  logic [70:0] mast_pt_in,
  output logic [34:0] mast_pt_out,
  wb_dma_wb_mst_ctrl_if.master wb
);

  state_t      state, state_nxt;
  logic [31:0] adr_r, dat_r, dout_r;
  logic [3:0]  sel_r;
  logic        we_r, cyc_r;
  logic        ld_req, drdy, err;
  logic        clr_all, clr_to, inc_rty, inc_to;
  logic        rty_exp, to_exp;
  logic        pt_mode, pt_cyc;

  assign pt_cyc = mast_pt_in[PT_CYC];

  wb_dma_wb_mst_ctrl_tmr #(
    .RTY_MAX (RTY_MAX),
    .TO_CYC  (TO_CYC)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr_all (clr_all),
    .clr_to  (clr_to),
    .inc_rty (inc_rty),
    .inc_to  (inc_to),
    .rty_exp (rty_exp),
    .to_exp  (to_exp)
  );

  // State register; reset drops any in-flight cycle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the same-cycle engine completion strobes
  always_comb begin
    state_nxt = state;
    ld_req    = 1'b0;
    drdy      = 1'b0;
    err       = 1'b0;
    clr_all   = 1'b0;
    clr_to    = 1'b0;
    inc_rty   = 1'b0;
    inc_to    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Host wins a same-cycle tie with the engine
        if (pt_cyc) begin
          state_nxt = ST_PT;
        end else if (mast_go) begin
          state_nxt = ST_REQ;
          ld_req    = 1'b1;
          clr_all   = 1'b1;
        end
      end
      ST_REQ: begin
        if (wb.wb_err_i) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wb.wb_ack_i) begin
          drdy      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wb.wb_rty_i) begin
          if (rty_exp) begin
            err       = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            inc_rty   = 1'b1;
            state_nxt = ST_RETRY;
          end
        end else if (to_exp) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          inc_to = 1'b1;
        end
      end
      ST_RETRY: begin
        clr_to    = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_PT: begin
        if (!pt_cyc) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Engine bus registers: request captured on IDLE->REQ, cyc/stb track REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_r <= '0;
      dat_r <= '0;
      sel_r <= '0;
      we_r  <= 1'b0;
      cyc_r <= 1'b0;
    end else begin
      cyc_r <= (state_nxt == ST_REQ);
      if (ld_req) begin
        adr_r <= mast_adr;
        dat_r <= mast_din;
        sel_r <= mast_sel;
        we_r  <= mast_we;
      end
    end
  end

  // Read data is held after the completing ack until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               dout_r <= '0;
    else if (drdy && !we_r) dout_r <= wb.wb_data_i;
  end

  assign pt_mode = (state == ST_PT);

  assign wb.wb_addr_o = pt_mode ? mast_pt_in[PT_ADR +: 32]  : adr_r;
  assign wb.wb_data_o = pt_mode ? mast_pt_in[PT_DATA +: 32] : dat_r;
  assign wb.wb_sel_o  = pt_mode ? mast_pt_in[PT_SEL +: 4]   : sel_r;
  assign wb.wb_we_o   = pt_mode ? mast_pt_in[PT_WE]         : we_r;
  assign wb.wb_cyc_o  = pt_mode ? mast_pt_in[PT_CYC]        : cyc_r;
  assign wb.wb_stb_o  = pt_mode ? mast_pt_in[PT_STB]        : cyc_r;

  // The host only ever sees slave responses while it owns the bus
  assign mast_pt_out = pt_mode ? pt_resp(wb.wb_data_i, wb.wb_ack_i, wb.wb_err_i, wb.wb_rty_i)
                               : 35'h0;

  assign mast_dout = (drdy && !we_r) ? wb.wb_data_i : dout_r;
  assign mast_drdy = drdy;
  assign mast_err  = err;
  assign mast_busy = (state == ST_REQ) || (state == ST_RETRY);

endmodule

// File: tb/tb_wb_dma_wb_mst_ctrl.sv
// Bench for the DMA WISHBONE initiator: scripted slave responses per attempt,
// directed scenarios plus randomized transfers against an outcome model.
module tb_wb_dma_wb_mst_ctrl;
  localparam int RTY_MAX = 7;
  localparam int TO_CYC  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        mast_go, mast_we;
  logic [31:0] mast_adr, mast_din, mast_dout;
  logic [3:0]  mast_sel;
  logic        mast_drdy, mast_err, mast_busy;
  logic [70:0] mast_pt_in;
  logic [34:0] mast_pt_out;

  wb_dma_wb_mst_ctrl_if wb ();

  wb_dma_wb_mst_ctrl #(.RTY_MAX(RTY_MAX), .TO_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mast_go     (mast_go),
    .mast_we     (mast_we),
    .mast_adr    (mast_adr),
    .mast_sel    (mast_sel),
    .mast_din    (mast_din),
    .mast_dout   (mast_dout),
    .mast_drdy   (mast_drdy),
    .mast_err    (mast_err),
    .mast_busy   (mast_busy),
    .mast_pt_in  (mast_pt_in),
    .mast_pt_out (mast_pt_out),
    .wb          (wb.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Slave script: for attempt a, respond pk[a] ({err,ack,rty}) after pw[a] cyc cycles
  int          pw [16];
  logic [2:0]  pk [16];
  logic [31:0] rd [16];

  // Model expectations
  logic [31:0] model_dout;
  int          e_err, e_att, e_len;
  logic [31:0] e_dout;

  // Observations of one engine transfer
  int          o_drdy, o_err, o_att, o_len, o_lat;
  int          o_gapbad, o_adrbad, o_busybad, o_ptbad;
  logic [31:0] o_dout;
  bit          o_done;
  logic        o_cycafter;

  // Outcome of a transfer from the response rules: err beats ack beats rty,
  // the (RTY_MAX+1)-th retry fails, and a silent attempt fails after TO_CYC cycles.
  task automatic model(input logic we);
    int r;
    r = 0; e_err = 0; e_att = 0; e_len = 0;
    for (int a = 0; a < 16; a++) begin
      e_att = a + 1;
      if (pw[a] >= TO_CYC) begin e_err = 1; e_len = TO_CYC; break; end
      e_len = pw[a] + 1;
      if (pk[a][2]) begin e_err = 1; break; end
      if (pk[a][1]) break;
      if (r == RTY_MAX) begin e_err = 1; break; end
      r++;
    end
    e_dout = (e_err == 0 && !we) ? rd[e_att-1] : model_dout;
  endtask

  task automatic clear_script();
    for (int a = 0; a < 16; a++) begin
      pw[a] = 0; pk[a] = 3'b001; rd[a] = $urandom;
    end
  endtask

  // Runs one engine transfer cycle by cycle, acting as the scripted slave
  task automatic run_eng(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] din);
    bit in_cyc;
    int k, gap;
    o_drdy = 0; o_err = 0; o_att = 0; o_len = 0; o_lat = -1;
    o_gapbad = 0; o_adrbad = 0; o_busybad = 0; o_ptbad = 0;
    o_dout = '0; o_done = 0; o_cycafter = 1'b1;
    in_cyc = 0; k = 0; gap = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
      wb.wb_data_i = $urandom;
      if (o_done) begin
        mast_go = 1'b0;
        #1;
        o_cycafter = wb.wb_cyc_o;
        return;
      end
      if (c == 0) begin
        mast_go = 1'b1; mast_we = we; mast_adr = adr; mast_sel = sel; mast_din = din;
      end
      if (wb.wb_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1; o_att++; k = 0;
          if (o_att == 1) o_lat = c;
          else if (gap != 1) o_gapbad++;
        end else begin
          k++;
        end
        if (wb.wb_addr_o !== adr || wb.wb_sel_o !== sel || wb.wb_we_o !== we ||
            wb.wb_stb_o !== 1'b1 || (we && wb.wb_data_o !== din))
          o_adrbad++;
        if (o_att <= 16 && k == pw[o_att-1]) begin
          {wb.wb_err_i, wb.wb_ack_i, wb.wb_rty_i} = pk[o_att-1];
          wb.wb_data_i = rd[o_att-1];
        end
        o_len = k + 1;
      end else begin
        if (in_cyc) begin in_cyc = 0; gap = 0; end
        gap++;
      end
      #1;
      if (mast_busy !== (c > 0)) o_busybad++;
      if (mast_pt_out !== 35'h0) o_ptbad++;
      if (mast_drdy === 1'b1) begin o_drdy++; o_dout = mast_dout; o_done = 1; end
      if (mast_err === 1'b1) begin o_err++; o_done = 1; end
    end
    // Budget exhausted: recover with a reset so later scenarios can run
    mast_go = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_dout = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mast_go = 1'b0; mast_we = 1'b0; mast_adr = '0; mast_sel = '0; mast_din = '0;
    mast_pt_in = '0;
    wb.wb_data_i = '0; wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
    model_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({wb.wb_data_o, wb.wb_addr_o, wb.wb_sel_o, wb.wb_we_o, wb.wb_cyc_o, wb.wb_stb_o} !== 71'h0)
      $display("FAIL reset_bus got %h required 0",
               {wb.wb_data_o, wb.wb_addr_o, wb.wb_sel_o, wb.wb_we_o, wb.wb_cyc_o, wb.wb_stb_o});
    else n_pass++;
    n_chk++;
    if ({mast_dout, mast_drdy, mast_err, mast_busy, mast_pt_out} !== 70'h0)
      $display("FAIL reset_engine got %h required 0",
               {mast_dout, mast_drdy, mast_err, mast_busy, mast_pt_out});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_read();
    clear_script();
    pw[0] = 1; pk[0] = 3'b010; rd[0] = 32'hDEADBEEF;
    model(1'b0);
    run_eng(1'b0, 32'h100, 4'hF, 32'h0);
    n_chk++;
    if (o_lat !== 1) $display("FAIL read_latency got %0d required 1", o_lat); else n_pass++;
    n_chk++;
    if (o_drdy !== 1 || o_err !== 0)
      $display("FAIL read_outcome got drdy=%0d err=%0d required 1/0", o_drdy, o_err);
    else n_pass++;
    n_chk++;
    if (o_dout !== e_dout) $display("FAIL read_dout got %h required %h", o_dout, e_dout); else n_pass++;
    n_chk++;
    if (o_len !== e_len) $display("FAIL read_len got %0d required %0d", o_len, e_len); else n_pass++;
    n_chk++;
    if (o_cycafter !== 1'b0) $display("FAIL read_cyc_drop got %b required 0", o_cycafter); else n_pass++;
    model_dout = e_dout;
  endtask

  task automatic test_retry();
    clear_script();
    pk[3] = 3'b010; pw[1] = 1; pw[3] = 2;
    model(1'b1);
    run_eng(1'b1, 32'h0000_2000, 4'h3, 32'hA5A5A5A5);
    n_chk++;
    if (o_att !== e_att) $display("FAIL retry_attempts got %0d required %0d", o_att, e_att); else n_pass++;
    n_chk++;
    if (o_gapbad !== 0 || o_adrbad !== 0)
      $display("FAIL retry_gap_addr got gapbad=%0d adrbad=%0d required 0/0", o_gapbad, o_adrbad);
    else n_pass++;
    n_chk++;
    if (o_drdy !== 1 || o_err !== 0)
      $display("FAIL retry_outcome got drdy=%0d err=%0d required 1/0", o_drdy, o_err);
    else n_pass++;
    n_chk++;
    if (o_dout !== model_dout) $display("FAIL retry_dout_hold got %h required %h", o_dout, model_dout);
    else n_pass++;
    n_chk++;
    if (o_busybad !== 0) $display("FAIL retry_busy got %0d bad cycles required 0", o_busybad); else n_pass++;
  endtask

  task automatic test_limits();
    clear_script();
    model(1'b0);
    run_eng(1'b0, 32'h0000_3000, 4'hF, 32'h0);
    n_chk++;
    if (o_err !== 1 || o_drdy !== 0 || o_att !== e_att)
      $display("FAIL rty_limit got err=%0d drdy=%0d att=%0d required 1/0/%0d", o_err, o_drdy, o_att, e_att);
    else n_pass++;
    clear_script();
    pw[0] = 1000;
    model(1'b0);
    run_eng(1'b0, 32'h0000_3004, 4'hF, 32'h0);
    n_chk++;
    if (o_err !== 1 || o_drdy !== 0)
      $display("FAIL timeout_outcome got err=%0d drdy=%0d required 1/0", o_err, o_drdy);
    else n_pass++;
    n_chk++;
    if (o_len !== e_len) $display("FAIL timeout_len got %0d required %0d", o_len, e_len); else n_pass++;
    n_chk++;
    if (o_cycafter !== 1'b0) $display("FAIL timeout_cyc_drop got %b required 0", o_cycafter); else n_pass++;
  endtask

  task automatic test_priority();
    clear_script();
    pk[0] = 3'b110;
    model(1'b0);
    run_eng(1'b0, 32'h0000_4000, 4'hF, 32'h0);
    n_chk++;
    if (o_err !== 1 || o_drdy !== 0)
      $display("FAIL prio_ack_err got err=%0d drdy=%0d required 1/0", o_err, o_drdy);
    else n_pass++;
    clear_script();
    pk[0] = 3'b011; pw[0] = 2;
    model(1'b0);
    run_eng(1'b0, 32'h0000_4004, 4'hF, 32'h0);
    n_chk++;
    if (o_drdy !== 1 || o_err !== 0 || o_att !== 1)
      $display("FAIL prio_ack_rty got drdy=%0d err=%0d att=%0d required 1/0/1", o_drdy, o_err, o_att);
    else n_pass++;
    n_chk++;
    if (o_dout !== e_dout) $display("FAIL prio_dout got %h required %h", o_dout, e_dout); else n_pass++;
    model_dout = e_dout;
  endtask

  task automatic test_random();
    logic [2:0]  kinds [5];
    logic        we;
    logic [31:0] adr, din;
    logic [3:0]  sel;
    int          n;
    kinds = '{3'b010, 3'b100, 3'b011, 3'b110, 3'b001};
    for (int t = 0; t < 25; t++) begin
      clear_script();
      n = $urandom_range(1, 9);
      for (int a = 0; a < 16; a++) pw[a] = $urandom_range(0, 3);
      pk[n-1] = kinds[$urandom_range(0, 4)];
      we = 1'($urandom); adr = $urandom; din = $urandom; sel = 4'($urandom);
      model(we);
      run_eng(we, adr, sel, din);
      n_chk++;
      if (o_err !== e_err || o_drdy !== 1 - e_err)
        $display("FAIL rnd%0d_outcome got err=%0d drdy=%0d required err=%0d", t, o_err, o_drdy, e_err);
      else n_pass++;
      n_chk++;
      if (o_att !== e_att || o_len !== e_len)
        $display("FAIL rnd%0d_shape got att=%0d len=%0d required %0d/%0d", t, o_att, o_len, e_att, e_len);
      else n_pass++;
      n_chk++;
      if (o_gapbad !== 0 || o_adrbad !== 0 || o_busybad !== 0 || o_ptbad !== 0 || o_lat !== 1)
        $display("FAIL rnd%0d_bus got gap=%0d adr=%0d busy=%0d pt=%0d lat=%0d required 0/0/0/0/1",
                 t, o_gapbad, o_adrbad, o_busybad, o_ptbad, o_lat);
      else n_pass++;
      if (e_err == 0) begin
        n_chk++;
        if (o_dout !== e_dout) $display("FAIL rnd%0d_dout got %h required %h", t, o_dout, e_dout);
        else n_pass++;
      end
      n_chk++;
      if (o_cycafter !== 1'b0) $display("FAIL rnd%0d_cyc_drop got %b required 0", t, o_cycafter);
      else n_pass++;
      model_dout = e_dout;
    end
  endtask

  task automatic test_pass_through();
    logic [31:0] pt_adr, pt_dat, rdat, eng_adr;
    int          waited;
    pt_adr = $urandom; pt_dat = $urandom; rdat = $urandom; eng_adr = 32'h0000_5000;
    @(posedge clk); #1;
    mast_pt_in = {pt_dat, pt_adr, 4'hC, 1'b1, 1'b1, 1'b1};
    mast_go = 1'b1; mast_we = 1'b0; mast_adr = eng_adr; mast_sel = 4'h3;
    @(posedge clk); #1;
    wb.wb_ack_i = 1'b1; wb.wb_data_i = rdat;
    #1;
    n_chk++;
    if (wb.wb_addr_o !== pt_adr || wb.wb_data_o !== pt_dat || wb.wb_cyc_o !== 1'b1 || mast_busy !== 1'b0)
      $display("FAIL pt_grant got adr=%h dat=%h cyc=%b busy=%b required %h/%h/1/0",
               wb.wb_addr_o, wb.wb_data_o, wb.wb_cyc_o, mast_busy, pt_adr, pt_dat);
    else n_pass++;
    n_chk++;
    if (mast_pt_out !== {rdat, 3'b100})
      $display("FAIL pt_ack_route got %h required %h", mast_pt_out, {rdat, 3'b100});
    else n_pass++;
    @(posedge clk); #1;
    wb.wb_ack_i = 1'b0;
    mast_pt_in = '0;
    @(posedge clk); #1; #1;
    n_chk++;
    if (wb.wb_cyc_o !== 1'b0) $display("FAIL pt_idle_gap got cyc=%b required 0", wb.wb_cyc_o); else n_pass++;
    waited = 0;
    while (wb.wb_cyc_o !== 1'b1 && waited < 4) begin
      @(posedge clk); #1; #1;
      waited++;
    end
    n_chk++;
    if (wb.wb_cyc_o !== 1'b1 || wb.wb_addr_o !== eng_adr || mast_busy !== 1'b1)
      $display("FAIL pt_engine_follow got cyc=%b adr=%h busy=%b required 1/%h/1",
               wb.wb_cyc_o, wb.wb_addr_o, mast_busy, eng_adr);
    else n_pass++;
    wb.wb_ack_i = 1'b1; wb.wb_data_i = rdat ^ 32'hFFFF_0000;
    #1;
    n_chk++;
    if (mast_drdy !== 1'b1 || mast_dout !== (rdat ^ 32'hFFFF_0000) || mast_pt_out !== 35'h0)
      $display("FAIL pt_engine_done got drdy=%b dout=%h ptout=%h required 1/%h/0",
               mast_drdy, mast_dout, mast_pt_out, rdat ^ 32'hFFFF_0000);
    else n_pass++;
    model_dout = rdat ^ 32'hFFFF_0000;
    @(posedge clk); #1;
    wb.wb_ack_i = 1'b0; mast_go = 1'b0;
  endtask

  task automatic test_reset_in_req();
    @(posedge clk); #1;
    mast_go = 1'b1; mast_we = 1'b0; mast_adr = 32'h0000_6000; mast_sel = 4'hF;
    @(posedge clk); #1;
    wb.wb_ack_i = 1'b1; wb.wb_data_i = 32'h1234_5678;
    #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, mast_drdy, mast_err, mast_busy} !== 5'b0)
      $display("FAIL rst_req_async got %b required 00000",
               {wb.wb_cyc_o, wb.wb_stb_o, mast_drdy, mast_err, mast_busy});
    else n_pass++;
    model_dout = '0;
    @(posedge clk); #1;
    rst = 1'b0; mast_go = 1'b0; wb.wb_ack_i = 1'b0;
    @(posedge clk); #1; #1;
    n_chk++;
    if ({wb.wb_cyc_o, mast_busy, mast_drdy, mast_err} !== 4'b0 || mast_dout !== model_dout)
      $display("FAIL rst_req_idle got cyc/busy/drdy/err=%b dout=%h required 0000/%h",
               {wb.wb_cyc_o, mast_busy, mast_drdy, mast_err}, mast_dout, model_dout);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_retry();
    test_limits();
    test_priority();
    test_random();
    test_pass_through();
    test_reset_in_req();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
